// File: rtl/rgb565_frame_reader_pkg.sv
// rgb565_frame_reader_pkg
// Constants and types shared by the RGB565 frame reader and the RGB888->RGB565
// writer stage: frame geometry, RAM widths, reader FSM encoding and the
// RGB565 -> RGB888 expansion function.
package rgb565_frame_reader_pkg;

    localparam int IMG_W      = 480;
    localparam int IMG_H      = 272;
    localparam int FRAME_SIZE = IMG_W * IMG_H;   // 130560 words
    localparam int ADDR_WIDTH = 17;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit replication: the top bits of each channel are copied into the
    // vacated LSBs so that full-scale maps to 0xFF and zero stays zero.
    function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] rgb565);
        return {rgb565[15:11], rgb565[15:13],
                rgb565[10:5],  rgb565[10:9],
                rgb565[4:0],   rgb565[4:2]};
    endfunction

endpackage

// File: rtl/rgb565_frame_reader_if.sv
// rgb565_frame_reader_if
// Bundles the frame-RAM read port and the RGB888 pixel stream of the frame
// reader.
//   o_mem_addr / o_mem_rd_en : read request towards the frame RAM
//   i_mem_data               : RAM word, valid one clock after o_mem_rd_en
//   o_pixel, o_col, o_row,
//   o_sof, o_eol, o_eof      : stream payload, qualified by o_valid
//   o_valid / i_ready        : stream handshake
// master = the reader, slave = RAM plus downstream consumer.
interface rgb565_frame_reader_if #(
    parameter int ADDR_WIDTH = rgb565_frame_reader_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = rgb565_frame_reader_pkg::DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  o_mem_rd_en;
    logic [DATA_WIDTH-1:0] i_mem_data;
    logic [23:0]           o_pixel;
    logic                  o_valid;
    logic                  i_ready;
    logic [8:0]            o_col;
    logic [8:0]            o_row;
    logic                  o_sof;
    logic                  o_eol;
    logic                  o_eof;

    modport master (
        output o_mem_addr, o_mem_rd_en,
        output o_pixel, o_valid, o_col, o_row, o_sof, o_eol, o_eof,
        input  i_mem_data, i_ready
    );

    modport slave (
        input  o_mem_addr, o_mem_rd_en,
        input  o_pixel, o_valid, o_col, o_row, o_sof, o_eol, o_eof,
        output i_mem_data, i_ready
    );
endinterface

// File: rtl/rgb565_frame_reader_pix_skid_buf.sv
// rgb565_frame_reader_pix_skid_buf
// Two-entry valid/ready buffer. The head entry drives the output directly from
// a register, so the payload is stable while valid is high and not popped.
//   clk, srst : clock, synchronous active-high reset
//   push, din : write one entry (caller guarantees it is never pushed full)
//   pop       : remove the head entry (only meaningful while valid)
//   valid     : head entry holds data
//   dout      : head entry payload
//   count     : number of occupied entries (0..2)
module rgb565_frame_reader_pix_skid_buf #(
    parameter int W = 45
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] head_reg;
    logic [W-1:0] tail_reg;
    logic [1:0]   count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        head_reg <= din;
                    end else begin
                        tail_reg <= din;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    head_reg  <= tail_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word goes behind whatever
                    // remains after the pop.
                    if (count_reg == 2'd2) begin
                        head_reg <= tail_reg;
                        tail_reg <= din;
                    end else begin
                        head_reg <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (count_reg != 2'd0);
    assign dout  = head_reg;
    assign count = count_reg;

endmodule

// File: rtl/rgb565_frame_reader.sv
// rgb565_frame_reader
// Reads one RGB565 frame (IMG_W x IMG_H words, raster order) from the frame
// RAM, expands each word to RGB888 and streams it with column/row and
// start-of-frame / end-of-line / end-of-frame markers.
//   iClk, iRst : clock, synchronous active-high reset
//   i_Clk_en   : global enable; low freezes everything except RAM return capture
//   i_start    : one-cycle pulse, starts a frame when idle
//   bus        : RAM read port + pixel stream (rgb565_frame_reader_if.master)
//   o_busy     : high from leaving IDLE until DONE
//   o_done     : one-cycle pulse after the last pixel transfer
module rgb565_frame_reader #(
    parameter int IMG_W      = rgb565_frame_reader_pkg::IMG_W,
    parameter int IMG_H      = rgb565_frame_reader_pkg::IMG_H,
    parameter int ADDR_WIDTH = rgb565_frame_reader_pkg::ADDR_WIDTH
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  i_Clk_en,
    input  logic                  i_start,
    rgb565_frame_reader_if.master bus,
    output logic                  o_busy,
    output logic                  o_done
);
    import rgb565_frame_reader_pkg::*;

    localparam int META_W = 9 + 9 + 3;      // col, row, sof, eol, eof
    localparam int PAY_W  = 24 + META_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [8:0]            LAST_COL  = 9'(IMG_W - 1);

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [8:0]            col_reg;
    logic [8:0]            row_reg;
    logic [META_W-1:0]     meta_reg;      // markers of the read currently in flight
    logic                  inflight_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic                  buf_valid;
    logic [1:0]            buf_count;
    logic [PAY_W-1:0]      buf_din;
    logic [PAY_W-1:0]      buf_dout;
    logic                  xfer;
    logic                  issue;
    logic [2:0]            pending;

    assign xfer    = buf_valid & bus.i_ready & i_Clk_en;
    assign pending = {1'b0, buf_count} + {2'b00, inflight_reg};

    // A read may issue only if, after this cycle's transfer, the buffer still
    // has a free slot for the returning word. Comparing against 2+xfer avoids
    // an unsigned subtraction.
    assign issue = (state_reg == ST_READ) & i_Clk_en & ~iRst
                 & (pending < (3'd2 + {2'b00, xfer}));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            meta_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else if (i_Clk_en) begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (i_start) begin
                        state_reg <= ST_READ;
                        busy_reg  <= 1'b1;
                        addr_reg  <= '0;
                        col_reg   <= '0;
                        row_reg   <= '0;
                    end
                end
                ST_READ: begin
                    if (issue && addr_reg == LAST_ADDR) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Look ahead by one transfer so o_done lands in the cycle
                    // right after the last pixel leaves.
                    if (!inflight_reg &&
                        (buf_count == 2'd0 || (buf_count == 2'd1 && xfer))) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (issue) begin
                addr_reg <= addr_reg + 1'b1;
                meta_reg <= {col_reg, row_reg,
                             addr_reg == '0,
                             col_reg == LAST_COL,
                             addr_reg == LAST_ADDR};
                if (col_reg == LAST_COL) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 9'd1;
                end else begin
                    col_reg <= col_reg + 9'd1;
                end
            end
        end
    end

    // The RAM word arrives exactly one clock after the strobe whatever the
    // enable does, so the in-flight flag follows the strobe unconditionally.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
        end
    end

    assign buf_din = {rgb565_to_rgb888(bus.i_mem_data), meta_reg};

    rgb565_frame_reader_pix_skid_buf #(
        .W(PAY_W)
    ) u_skid (
        .clk   (iClk),
        .srst  (iRst),
        .push  (inflight_reg),
        .din   (buf_din),
        .pop   (xfer),
        .valid (buf_valid),
        .dout  (buf_dout),
        .count (buf_count)
    );

    assign bus.o_mem_addr  = addr_reg;
    assign bus.o_mem_rd_en = issue;
    assign bus.o_valid     = buf_valid;
    assign bus.o_pixel     = buf_dout[PAY_W-1 -: 24];
    assign bus.o_col       = buf_dout[20:12];
    assign bus.o_row       = buf_dout[11:3];
    assign bus.o_sof       = buf_dout[2];
    assign bus.o_eol       = buf_dout[1];
    assign bus.o_eof       = buf_dout[0];
    assign o_busy          = busy_reg;
    assign o_done          = done_reg;

endmodule
